// File: rtl/bounce_pkg.sv
// bounce_pkg: shared state encoding and LFSR constants for the bounce generator
package bounce_pkg;
  typedef enum logic [2:0] {IDLE, HI, LO, SETTLE, DONE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/bounce_gen_lfsr16.sv
// lfsr16: 16-bit right-shift Galois LFSR that advances only when asked
module lfsr16
  import bounce_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  input  logic [15:0]  seed,
  output logic [W-1:0] value
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = adv ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0)) : lfsr_q;
  assign value = lfsr_q[W-1:0];
  always_ff @(posedge clk)
    if (reset) lfsr_q <= seed;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: drives q to a target level through pseudo-random contact-bounce glitches
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          CNT_W        = 8,
  parameter int          MAX_GLITCHES = 8,
  parameter int          MIN_SETTLE   = 4,
  parameter logic [15:0] SEED         = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             target,
  input  logic [3:0]       glitch_count,
  input  logic [CNT_W-1:0] max_width,
  output logic             q,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic tgt_q, tgt_d, q_q, q_d, busy_q, busy_d, done_q, done_d, adv;
  logic [3:0] rem_q, rem_d, n_in;
  logic [CNT_W-1:0] mw_q, mw_d, cnt_q, cnt_d, mw_in, mw_sel, rnd, w_min, w;
  lfsr16 #(.W(CNT_W)) u_lfsr (.clk(clk), .reset(reset), .adv(adv), .seed(SEED), .value(rnd));
  assign n_in = (glitch_count > 4'(MAX_GLITCHES)) ? 4'(MAX_GLITCHES) : glitch_count;
  assign mw_in = (max_width == '0) ? CNT_W'(1) : max_width;
  // the width limit is not latched yet on the cycle start is accepted
  assign mw_sel = (state_q == IDLE) ? mw_in : mw_q;
  assign w_min = (rnd < mw_sel) ? rnd : mw_sel;
  assign w = (w_min == '0) ? CNT_W'(1) : w_min;
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    rem_d = rem_q;
    mw_d = mw_q;
    cnt_d = cnt_q;
    adv = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        tgt_d = target;
        rem_d = n_in;
        mw_d = mw_in;
        state_d = (n_in != 4'd0) ? HI : SETTLE;
        cnt_d = (n_in != 4'd0) ? w : CNT_W'(MIN_SETTLE);
        adv = (n_in != 4'd0);
      end
      HI: if (cnt_q == CNT_W'(1)) begin
        state_d = LO;
        cnt_d = w;
        adv = 1'b1;
      end else cnt_d = cnt_q - CNT_W'(1);
      LO: if (cnt_q == CNT_W'(1)) begin
        state_d = (rem_q > 4'd1) ? HI : SETTLE;
        rem_d = rem_q - 4'd1;
        cnt_d = (rem_q > 4'd1) ? w : CNT_W'(MIN_SETTLE);
        adv = (rem_q > 4'd1);
      end else cnt_d = cnt_q - CNT_W'(1);
      SETTLE: if (cnt_q == CNT_W'(1)) state_d = DONE;
        else cnt_d = cnt_q - CNT_W'(1);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    q_d = (state_d == LO) ? ~tgt_d : (state_d == IDLE) ? q_q : tgt_d;
    busy_d = (state_d == HI) || (state_d == LO) || (state_d == SETTLE);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      tgt_q <= 1'b0;
      rem_q <= 4'd0;
      mw_q <= '0;
      cnt_q <= '0;
      q_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      rem_q <= rem_d;
      mw_q <= mw_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign q = q_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed self-checking bench for bounce_gen
module tb_bounce_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic target = 1'b0;
  logic [3:0] glitch_count = 4'd0;
  logic [7:0] max_width = 8'd1;
  logic q, busy, done;
  int total = 0;
  int bad = 0;
  bit q_tr[$];
  bit b_tr[$];
  bit d_tr[$];

  bounce_gen dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .glitch_count(glitch_count), .max_width(max_width),
    .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit t, input logic [3:0] gc, input logic [7:0] mw, input bit hold);
    target = t;
    glitch_count = gc;
    max_width = mw;
    start = 1'b1;
    tick();
    start = hold;
  endtask

  // records q/busy/done each cycle up to and including the done cycle
  task automatic capture(input int maxc);
    q_tr.delete();
    b_tr.delete();
    d_tr.delete();
    for (int i = 0; i < maxc; i++) begin
      q_tr.push_back(q);
      b_tr.push_back(busy);
      d_tr.push_back(done);
      if (done) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (q !== 1'b0) begin bad++; $display("FAIL reset_q got=%b want=0", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({q, busy, done} !== 3'b000) begin
        bad++; $display("FAIL idle_hold cyc=%0d got=%b%b%b want=000", i, q, busy, done);
      end
    end
  endtask

  task automatic test_bounce();
    bit eq[9] = '{1, 0, 1, 0, 1, 1, 1, 1, 1};
    bit eb[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    pulse_start(1'b1, 4'd2, 8'd1, 1'b0);
    capture(40);
    total++;
    if (q_tr.size() != 9) begin bad++; $display("FAIL bounce_len got=%0d want=9", q_tr.size()); end
    for (int i = 0; i < 9 && i < q_tr.size(); i++) begin
      total++;
      if ({q_tr[i], b_tr[i], d_tr[i]} !== {eq[i], eb[i], i == 8}) begin
        bad++; $display("FAIL bounce_trace idx=%0d got=%b%b%b want=%b%b%b", i, q_tr[i], b_tr[i], d_tr[i], eq[i], eb[i], i == 8);
      end
    end
    tick();
    total++; if (done !== 1'b0 || q !== 1'b1) begin bad++; $display("FAIL bounce_after got q=%b done=%b want q=1 done=0", q, done); end
  endtask

  task automatic test_no_glitch(input bit t);
    pulse_start(t, 4'd0, 8'd7, 1'b0);
    capture(20);
    total++;
    if (q_tr.size() != 5) begin bad++; $display("FAIL noglitch_len t=%b got=%0d want=5", t, q_tr.size()); end
    for (int i = 0; i < q_tr.size(); i++) begin
      total++;
      if ({q_tr[i], b_tr[i], d_tr[i]} !== {t, i != 4, i == 4}) begin
        bad++; $display("FAIL noglitch_trace t=%b idx=%0d got=%b%b%b want=%b%b%b", t, i, q_tr[i], b_tr[i], d_tr[i], t, i != 4, i == 4);
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    int rise = 0;
    int fall = 0;
    bit prev = q;
    pulse_start(1'b1, 4'd15, 8'd1, 1'b0);
    capture(60);
    foreach (q_tr[i]) begin
      if (!prev && q_tr[i]) rise++;
      if (prev && !q_tr[i]) fall++;
      prev = q_tr[i];
    end
    total++; if (q_tr.size() != 21) begin bad++; $display("FAIL clamp_len got=%0d want=21", q_tr.size()); end
    total++; if (rise != 8) begin bad++; $display("FAIL clamp_rise got=%0d want=8", rise); end
    total++; if (fall != 8) begin bad++; $display("FAIL clamp_fall got=%0d want=8", fall); end
    total++; if (prev !== 1'b1) begin bad++; $display("FAIL clamp_final got=%b want=1", prev); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit eq[9] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    int dn = 0;
    pulse_start(1'b0, 4'd2, 8'd1, 1'b1);
    capture(40);
    start = 1'b0;
    foreach (d_tr[i]) dn += int'(d_tr[i]);
    total++; if (q_tr.size() != 9) begin bad++; $display("FAIL b2b_len got=%0d want=9", q_tr.size()); end
    for (int i = 0; i < 9 && i < q_tr.size(); i++) begin
      total++;
      if (q_tr[i] !== eq[i]) begin bad++; $display("FAIL b2b_q idx=%0d got=%b want=%b", i, q_tr[i], eq[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      dn += int'(done);
      total++;
      if ({q, busy} !== 2'b00) begin bad++; $display("FAIL b2b_idle cyc=%0d got q=%b busy=%b want 00", i, q, busy); end
    end
    total++; if (dn != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", dn); end
  endtask

  task automatic test_zero_width();
    bit eq[7] = '{0, 1, 0, 0, 0, 0, 0};
    pulse_start(1'b0, 4'd1, 8'd0, 1'b0);
    capture(30);
    total++; if (q_tr.size() != 7) begin bad++; $display("FAIL zw_len got=%0d want=7", q_tr.size()); end
    for (int i = 0; i < 7 && i < q_tr.size(); i++) begin
      total++;
      if (q_tr[i] !== eq[i]) begin bad++; $display("FAIL zw_q idx=%0d got=%b want=%b", i, q_tr[i], eq[i]); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pulse_start(1'b1, 4'd1, 8'd5, 1'b0);
    tick();
    tick();
    total++; if ({q, busy} !== 2'b11) begin bad++; $display("FAIL mid_pre got q=%b busy=%b want 11", q, busy); end
    reset = 1'b1;
    tick();
    total++; if ({q, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_abort got=%b%b%b want=000", q, busy, done); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dn += int'(done) + int'(busy);
    end
    total++; if (dn != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dn); end
    // first two phases come from the reseeded LFSR: 0xE1 and 0x70, both capped at 5
    pulse_start(1'b1, 4'd1, 8'd5, 1'b0);
    capture(40);
    total++; if (q_tr.size() != 15) begin bad++; $display("FAIL mid_rerun_len got=%0d want=15", q_tr.size()); end
    for (int i = 0; i < 15 && i < q_tr.size(); i++) begin
      total++;
      if (q_tr[i] !== bit'(i < 5 || i >= 10)) begin
        bad++; $display("FAIL mid_rerun_q idx=%0d got=%b want=%b", i, q_tr[i], i < 5 || i >= 10);
      end
    end
    tick();
  endtask

  task automatic test_long_width();
    int errs = 0;
    int first = -1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    // after reseed: HI = min(0xE1,200)=200, LO = min(0x70,200)=112, then 4 settle + done
    pulse_start(1'b1, 4'd1, 8'd200, 1'b0);
    capture(400);
    total++; if (q_tr.size() != 317) begin bad++; $display("FAIL long_len got=%0d want=317", q_tr.size()); end
    foreach (q_tr[i]) if (q_tr[i] !== bit'(i < 200 || i >= 312)) begin
      errs++;
      if (first < 0) first = i;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL long_trace mismatches=%0d first_idx=%0d want=0", errs, first); end
    tick();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_no_glitch(1'b0);
    test_no_glitch(1'b1);
    test_clamp();
    test_back_to_back();
    test_zero_width();
    test_reset_mid();
    test_long_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
